// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result packet transmitter.
package result_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int PKT_LEN = 9;
  localparam int IDX_W   = $clog2(PKT_LEN);

  localparam logic [1:0] CH1_ID = 2'b01;
  localparam logic [1:0] CH2_ID = 2'b10;

  // One channel's frame result as captured at frm_done.
  typedef struct packed {
    logic        dir;
    logic [11:0] cx;
    logic [11:0] cy;
    logic [9:0]  ax;
    logic [9:0]  ay;
  } ch_snap_t;

endpackage

// File: rtl/result_pkt_byte.sv
// Combinational packet formatter: selects one byte of a 9-byte result packet,
// checksum included.
module result_pkt_byte
  import result_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input  ch_snap_t         snap,
  input  logic [1:0]       ch_id,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       pkt_byte
);

  logic [7:0] b1, b2, b3, b4, b5, b6, b7, csum;

  assign b1   = {ch_id, snap.dir, 1'b0, snap.cx[11:8]};
  assign b2   = snap.cx[7:0];
  assign b3   = {4'b0, snap.cy[11:8]};
  assign b4   = snap.cy[7:0];
  assign b5   = {snap.ax[9:8], snap.ay[9:8], 4'b0};
  assign b6   = snap.ax[7:0];
  assign b7   = snap.ay[7:0];
  assign csum = b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6 ^ b7;

  always_comb begin
    pkt_byte = '0;
    case (idx)
      IDX_W'(0): pkt_byte = SYNC_BYTE;
      IDX_W'(1): pkt_byte = b1;
      IDX_W'(2): pkt_byte = b2;
      IDX_W'(3): pkt_byte = b3;
      IDX_W'(4): pkt_byte = b4;
      IDX_W'(5): pkt_byte = b5;
      IDX_W'(6): pkt_byte = b6;
      IDX_W'(7): pkt_byte = b7;
      IDX_W'(8): pkt_byte = csum;
      default:   pkt_byte = '0;
    endcase
  end

endmodule

// File: rtl/result_tx_sched.sv
// Frame-result transmit scheduler: snapshots per-channel results at frame end
// and streams them as checksummed byte packets over a valid/ready link.
module result_tx_sched
  import result_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter int         FRAME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm_done,
  input  logic        ch1_valid,
  input  logic        ch2_valid,
  input  logic [11:0] ch1_cx,
  input  logic [11:0] ch2_cx,
  input  logic [11:0] ch1_cy,
  input  logic [11:0] ch2_cy,
  input  logic [9:0]  ch1_ax,
  input  logic [9:0]  ch2_ax,
  input  logic [9:0]  ch1_ay,
  input  logic [9:0]  ch2_ay,
  input  logic        ch1_dir,
  input  logic        ch2_dir,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  state_t           state;
  logic [7:0]       div_cnt;
  logic             rr_ch2;
  logic             cur_ch2;
  logic             second_pend;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  ch_snap_t         snap1, snap2, cur_snap;
  logic [1:0]       cur_id;
  logic [7:0]       next_byte;
  logic             xfer;
  logic             last_byte;
  logic             trigger;

  assign cur_snap  = cur_ch2 ? snap2 : snap1;
  assign cur_id    = cur_ch2 ? CH2_ID : CH1_ID;
  assign idx_next  = idx + IDX_W'(1);
  assign xfer      = tx_valid && tx_ready;
  assign last_byte = (idx == IDX_W'(PKT_LEN - 1));
  assign trigger   = (div_cnt == DIV_LAST) && (ch1_valid || ch2_valid);

  // The formatter looks one byte ahead so tx_data can be registered.
  result_pkt_byte #(.SYNC_BYTE(SYNC_BYTE)) u_pkt_byte (
    .snap     (cur_snap),
    .ch_id    (cur_id),
    .idx      (idx_next),
    .pkt_byte (next_byte)
  );

  // Snapshot path: data only, no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && frm_done) begin
      snap1 <= {ch1_dir, ch1_cx, ch1_cy, ch1_ax, ch1_ay};
      snap2 <= {ch2_dir, ch2_cx, ch2_cy, ch2_ax, ch2_ay};
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      drop_cnt    <= '0;
      div_cnt     <= '0;
      rr_ch2      <= 1'b0;
      cur_ch2     <= 1'b0;
      second_pend <= 1'b0;
      idx         <= '0;
    end else begin
      if (frm_done && state == SEND && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (frm_done) begin
            div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
            if (trigger) begin
              state       <= SEND;
              busy        <= 1'b1;
              tx_valid    <= 1'b1;
              tx_data     <= SYNC_BYTE;
              idx         <= '0;
              second_pend <= ch1_valid && ch2_valid;
              cur_ch2     <= ch2_valid && (!ch1_valid || rr_ch2);
              if (ch1_valid && ch2_valid)
                rr_ch2 <= !rr_ch2;
            end
          end
        end
        SEND: begin
          if (xfer) begin
            if (!last_byte) begin
              idx     <= idx_next;
              tx_data <= next_byte;
            end else if (second_pend) begin
              second_pend <= 1'b0;
              cur_ch2     <= !cur_ch2;
              idx         <= '0;
              tx_data     <= SYNC_BYTE;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_tx_sched.sv
// Self-checking bench for result_tx_sched: a byte-queue reference model runs
// alongside two instances (FRAME_DIV=1 and FRAME_DIV=3).
module tb_result_tx_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i      [2];
  logic        frm_done_i [2];
  logic        ch1_valid, ch2_valid, ch1_dir, ch2_dir;
  logic [11:0] ch1_cx, ch2_cx, ch1_cy, ch2_cy;
  logic [9:0]  ch1_ax, ch2_ax, ch1_ay, ch2_ay;
  logic        tx_ready;
  logic [7:0]  tx_data_o  [2];
  logic        tx_valid_o [2];
  logic        busy_o     [2];
  logic [7:0]  drop_o     [2];

  result_tx_sched #(.SYNC_BYTE(8'hAA), .FRAME_DIV(1)) u_dut (
    .clk(clk), .rst(rst_i[0]), .frm_done(frm_done_i[0]),
    .ch1_valid(ch1_valid), .ch2_valid(ch2_valid),
    .ch1_cx(ch1_cx), .ch2_cx(ch2_cx), .ch1_cy(ch1_cy), .ch2_cy(ch2_cy),
    .ch1_ax(ch1_ax), .ch2_ax(ch2_ax), .ch1_ay(ch1_ay), .ch2_ay(ch2_ay),
    .ch1_dir(ch1_dir), .ch2_dir(ch2_dir),
    .tx_data(tx_data_o[0]), .tx_valid(tx_valid_o[0]), .tx_ready(tx_ready),
    .busy(busy_o[0]), .drop_cnt(drop_o[0])
  );

  result_tx_sched #(.SYNC_BYTE(8'hAA), .FRAME_DIV(3)) u_div (
    .clk(clk), .rst(rst_i[1]), .frm_done(frm_done_i[1]),
    .ch1_valid(ch1_valid), .ch2_valid(ch2_valid),
    .ch1_cx(ch1_cx), .ch2_cx(ch2_cx), .ch1_cy(ch1_cy), .ch2_cy(ch2_cy),
    .ch1_ax(ch1_ax), .ch2_ax(ch2_ax), .ch1_ay(ch1_ay), .ch2_ay(ch2_ay),
    .ch1_dir(ch1_dir), .ch2_dir(ch2_dir),
    .tx_data(tx_data_o[1]), .tx_valid(tx_valid_o[1]), .tx_ready(tx_ready),
    .busy(busy_o[1]), .drop_cnt(drop_o[1])
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the bytes still owed by each instance, in order.
  logic [7:0] eb [2][18];
  int         hd [2];
  int         cnt [2];
  int         div_m [2];
  int         drop_m [2];
  bit         rr_m [2];
  bit         was_rst [2];
  logic [7:0] log0 [$];

  task automatic fill(input int k, input int base, input bit ch2);
    logic [7:0] b [9];
    logic [1:0] id;
    logic d;
    logic [11:0] x, y;
    logic [9:0] a, c;
    id = ch2 ? 2'b10 : 2'b01;
    d  = ch2 ? ch2_dir : ch1_dir;
    x  = ch2 ? ch2_cx : ch1_cx;
    y  = ch2 ? ch2_cy : ch1_cy;
    a  = ch2 ? ch2_ax : ch1_ax;
    c  = ch2 ? ch2_ay : ch1_ay;
    b[0] = 8'hAA;
    b[1] = {id, d, 1'b0, x[11:8]};
    b[2] = x[7:0];
    b[3] = {4'b0, y[11:8]};
    b[4] = y[7:0];
    b[5] = {a[9:8], c[9:8], 4'b0};
    b[6] = a[7:0];
    b[7] = c[7:0];
    b[8] = 8'h00;
    for (int j = 1; j < 8; j++) b[8] = b[8] ^ b[j];
    for (int j = 0; j < 9; j++) eb[k][base + j] = b[j];
  endtask

  task automatic model_step(input int k);
    bit busy_m, trig;
    int divn;
    busy_m     = (cnt[k] != 0);
    divn       = (k == 0) ? 1 : 3;
    was_rst[k] = rst_i[k];
    if (rst_i[k]) begin
      cnt[k] = 0; hd[k] = 0; drop_m[k] = 0; div_m[k] = 0; rr_m[k] = 0;
      return;
    end
    if (busy_m && tx_ready) begin
      hd[k]++;
      cnt[k]--;
    end
    if (frm_done_i[k]) begin
      if (busy_m) begin
        if (drop_m[k] < 255) drop_m[k]++;
      end else begin
        trig     = (div_m[k] == divn - 1);
        div_m[k] = trig ? 0 : div_m[k] + 1;
        if (trig && (ch1_valid || ch2_valid)) begin
          hd[k] = 0;
          if (ch1_valid && ch2_valid) begin
            fill(k, 0, rr_m[k]);
            fill(k, 9, !rr_m[k]);
            cnt[k]  = 18;
            rr_m[k] = !rr_m[k];
          end else begin
            fill(k, 0, ch2_valid);
            cnt[k] = 9;
          end
        end
      end
    end
  endtask

  always begin
    @(posedge clk);
    if (tx_valid_o[0] === 1'b1 && tx_ready) log0.push_back(tx_data_o[0]);
    model_step(0);
    model_step(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tx_valid[%0d]", k), tx_valid_o[k], cnt[k] != 0);
      chk($sformatf("busy[%0d]", k), busy_o[k], cnt[k] != 0);
      chk($sformatf("drop_cnt[%0d]", k), drop_o[k], drop_m[k]);
      if (cnt[k] != 0) chk($sformatf("tx_data[%0d]", k), tx_data_o[k], eb[k][hd[k]]);
      else if (was_rst[k]) chk($sformatf("rst_tx_data[%0d]", k), tx_data_o[k], 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int k);
    frm_done_i[k] = 1'b1;
    tick();
    frm_done_i[k] = 1'b0;
  endtask

  task automatic rand_ch();
    ch1_cx = 12'($urandom); ch2_cx = 12'($urandom);
    ch1_cy = 12'($urandom); ch2_cy = 12'($urandom);
    ch1_ax = 10'($urandom); ch2_ax = 10'($urandom);
    ch1_ay = 10'($urandom); ch2_ay = 10'($urandom);
    ch1_dir = 1'($urandom); ch2_dir = 1'($urandom);
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (log0.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("wait_log", log0.size() >= n, 1);
  endtask

  logic [7:0] exp1 [9];

  initial begin
    exp1 = '{8'hAA, 8'h61, 8'h23, 8'h00, 8'hF0, 8'h90, 8'hAB, 8'h55, 8'hDC};
    rst_i[0] = 1'b1; rst_i[1] = 1'b1;
    frm_done_i[0] = 1'b0; frm_done_i[1] = 1'b0;
    ch1_valid = 1'b0; ch2_valid = 1'b0; tx_ready = 1'b1;
    rand_ch();
    tick(3);
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    tick(2);

    // Single ch1 packet with known contents
    ch1_valid = 1'b1; ch2_valid = 1'b0;
    ch1_cx = 12'h123; ch1_cy = 12'h0F0; ch1_ax = 10'h2AB; ch1_ay = 10'h155; ch1_dir = 1'b1;
    log0.delete();
    pulse(0);
    chk("s1_first_valid", tx_valid_o[0], 1);
    chk("s1_first_sync", tx_data_o[0], 8'hAA);
    tick(12);
    chk("s1_len", log0.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("s1_byte%0d", i), log0[i], exp1[i]);

    // Both channels, two frames: round-robin order
    ch2_valid = 1'b1;
    rand_ch();
    log0.delete();
    pulse(0);
    wait_log(18, 40);
    chk("s2_f1_sync_a", log0[0], 8'hAA);
    chk("s2_f1_id_a", log0[1][7:6], 2'b01);
    chk("s2_f1_sync_b", log0[9], 8'hAA);
    chk("s2_f1_id_b", log0[10][7:6], 2'b10);
    tick(3);
    rand_ch();
    log0.delete();
    pulse(0);
    wait_log(18, 40);
    chk("s2_f2_id_a", log0[1][7:6], 2'b10);
    chk("s2_f2_id_b", log0[10][7:6], 2'b01);
    tick(3);

    // Back-pressure pattern 1,0,0 repeating
    ch2_valid = 1'b0;
    rand_ch();
    log0.delete();
    pulse(0);
    for (int c = 0; c < 40; c++) begin
      tx_ready = (c % 3 == 0);
      tick();
    end
    tx_ready = 1'b1;
    tick(2);
    chk("s3_len", log0.size(), 9);

    // Drops while busy, then saturation
    tx_ready = 1'b0;
    pulse(0);
    repeat (3) pulse(0);
    tick();
    chk("s4_drop3", drop_o[0], 3);
    repeat (300) pulse(0);
    tick();
    chk("s4_drop255", drop_o[0], 255);
    tx_ready = 1'b1;
    tick(15);

    // Frame divider of 3 on the second instance
    ch1_valid = 1'b1; ch2_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      pulse(1);
      chk($sformatf("s5_div_pulse%0d", i), busy_o[1], (i % 3) == 0);
      tick(14);
    end
    ch1_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      pulse(1);
      chk($sformatf("s5_invalid_pulse%0d", i), busy_o[1], 0);
      tick(4);
    end

    // Reset in the middle of a packet
    ch1_valid = 1'b1; ch2_valid = 1'b1;
    rand_ch();
    log0.delete();
    pulse(0);
    wait_log(4, 20);
    rst_i[0] = 1'b1;
    tick();
    rst_i[0] = 1'b0;
    chk("s6_abort_valid", tx_valid_o[0], 0);
    chk("s6_abort_busy", busy_o[0], 0);
    tick(3);
    log0.delete();
    pulse(0);
    wait_log(18, 40);
    chk("s6_restart_sync", log0[0], 8'hAA);
    chk("s6_restart_ch1", log0[1][7:6], 2'b01);
    tick(3);

    // Randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      frm_done_i[0] = ($urandom_range(5) == 0);
      frm_done_i[1] = ($urandom_range(5) == 0);
      rst_i[0]      = ($urandom_range(199) == 0);
      rst_i[1]      = ($urandom_range(199) == 0);
      ch1_valid     = 1'($urandom);
      ch2_valid     = 1'($urandom);
      tx_ready      = ($urandom_range(3) != 0);
      rand_ch();
      tick();
    end
    frm_done_i[0] = 1'b0; frm_done_i[1] = 1'b0;
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    tx_ready = 1'b1;
    tick(30);
    chk("end_idle0", busy_o[0], 0);
    chk("end_idle1", busy_o[1], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/result_tx_sched.md
RESULT_TX_SCHED -- requirements
Module: result_tx_sched

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hAA, packet header byte.
REQ-002 SHALL have parameter FRAME_DIV, default 1, transmit on every Nth accepted frame; legal range 1..255.
REQ-003 SHALL have port clk  in  1  single clock for all logic (the CMOS pixel clock domain).
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port frm_done  in  1  one-cycle pulse at frame end; channel results are stable in that cycle.
REQ-006 SHALL have ports ch1_valid/ch2_valid  in  1  object found in this frame.
REQ-007 SHALL have ports ch1_cx/ch2_cx and ch1_cy/ch2_cy  in  12  centre position.
REQ-008 SHALL have ports ch1_ax/ch2_ax and ch1_ay/ch2_ay  in  10  angle components.
REQ-009 SHALL have ports ch1_dir/ch2_dir  in  1  rotation direction.
REQ-010 SHALL have port tx_data  out  8  byte to UART transmitter.
REQ-011 SHALL have port tx_valid  out  1  tx_data valid.
REQ-012 SHALL have port tx_ready  in  1  transmitter accepts the byte.
REQ-013 SHALL have port busy  out  1  high while any packet is pending.
REQ-014 SHALL have port drop_cnt  out  8  count of frm_done pulses dropped while busy.

Function
REQ-015 The FSM SHALL have two states: IDLE and SEND. busy SHALL be registered and SHALL equal (state==SEND).
REQ-016 A frm_done in IDLE SHALL be accepted and SHALL advance a frame divider, which counts 0..FRAME_DIV-1 and then wraps to 0.
REQ-017 A frm_done accepted with divider==FRAME_DIV-1 while at least one chN_valid is high SHALL snapshot all channel inputs and enter SEND. tx_valid SHALL go high on the next cycle with tx_data=SYNC_BYTE.
REQ-018 An accepted trigger frame with both valids low SHALL send nothing and SHALL remain in IDLE.
REQ-019 Each packet SHALL be 9 bytes, in this order:
- SYNC_BYTE
- {ch_id[1:0], dir, 1'b0, cx[11:8]}
- cx[7:0]
- {4'b0, cy[11:8]}
- cy[7:0]
- {ax[9:8], ay[9:8], 4'b0}
- ax[7:0]
- ay[7:0]
- XOR of bytes 1..7
REQ-020 ch_id SHALL be 2'b01 for ch1 and 2'b10 for ch2.
REQ-021 A byte SHALL transfer only in a cycle with tx_valid && tx_ready. Otherwise tx_data and tx_valid SHALL hold, and tx_valid SHALL never drop before its transfer.
REQ-022 Bytes SHALL be back-to-back: after a transfer, the next byte (including the first byte of the second packet) SHALL be presented the following cycle with tx_valid held high.
REQ-023 When both channels are valid, two packets SHALL be sent. Order SHALL be set by a round-robin pointer (initially ch1) that toggles after each two-packet frame.
REQ-024 After the last byte transfers, the FSM SHALL return to IDLE, and tx_valid and busy SHALL be 0 the next cycle.
REQ-025 A frm_done while busy, including the final-transfer cycle, SHALL be dropped. drop_cnt SHALL increment and saturate at 255, and the frame divider SHALL NOT advance.

Reset
REQ-026 Under rst, the block SHALL set state=IDLE, tx_valid=0, tx_data=0, busy=0, drop_cnt=0, frame divider=0, round-robin pointer=ch1.
REQ-027 rst asserted mid-packet SHALL abort the packet, with tx_valid=0 on the next cycle; no partial packet SHALL resume afterwards.

Structure
REQ-028 Package result_tx_pkg SHALL hold:
- the state enum
- PKT_LEN=9
- the byte-index width
- the ch_id constants CH1_ID and CH2_ID
REQ-029 A combinational sub-module result_pkt_byte SHALL map (snapshot, ch_id, byte index) to the packet byte, including the checksum. The FSM, counters and handshake SHALL remain in result_tx_sched.

Verification
REQ-030 Scenario: ch1 only valid, cx=12'h123, cy=12'h0F0, ax=10'h2AB, ay=10'h155, dir=1; tx_ready=1.
- Required: AA,61,23,00,F0,90,AB,55,DC on 9 consecutive cycles, starting the cycle after frm_done.
REQ-031 Scenario: both channels valid, two frames.
- Required: frame 1 sends ch1 then ch2 (18 contiguous bytes); frame 2 sends ch2 then ch1.
REQ-032 Scenario: tx_ready toggles 1,0,0,1,...
- Required: tx_data stable whenever tx_valid&&!tx_ready; exactly 9 bytes per packet, none lost or duplicated.
REQ-033 Scenario: 3 frm_done pulses during SEND.
- Required: drop_cnt=3.
- Then 300 more pulses while busy: drop_cnt=255.
REQ-034 Scenario: FRAME_DIV=3, 6 spaced frm_done with ch1 valid.
- Required: packets only after pulses 3 and 6.
- All-invalid trigger frame: no output, busy stays 0.
REQ-035 Scenario: rst for one cycle at byte index 4.
- Required: next cycle tx_valid=0, busy=0.
- The following frm_done restarts with SYNC_BYTE and ch1 first.
